exers: RTL and testbench
========================

EXERS -- requirements
Module: exers

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of reservation-station entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port decode_exers_dispatch  in  1  dispatch request.
REQ-005 SHALL have ports decode_exers_op  in  5, decode_exers_robid  in  8, decode_exers_rd  in  6  carrying the ALU op code, ROB id and destination register.
REQ-006 SHALL have ports decode_exers_op1_rdy / decode_exers_op2_rdy  in  1  operand-valid flags.
REQ-007 SHALL have ports decode_exers_op1 / decode_exers_op2  in  32  operand values, meaningful only when the matching rdy flag is 1.
REQ-008 SHALL have ports decode_exers_op1_tag / decode_exers_op2_tag  in  8  producer ROB id, meaningful only when the matching rdy flag is 0.
REQ-009 SHALL have port exers_stall  out  1  meaning the station is full.
REQ-010 SHALL have port exers_scalu_issue  out  1  issue valid to the scalar ALU.
REQ-011 SHALL have ports exers_scalu_op  out  5, exers_robid  out  8, exers_rd  out  6, exers_op1 / exers_op2  out  32  carrying the issued entry.
REQ-012 SHALL have port scalu_stall  in  1  ALU backpressure.
REQ-013 SHALL have ports wb_valid  in  1, wb_robid  in  8, wb_result  in  32  forming the result broadcast bus.
REQ-014 SHALL have port rob_flush  in  1  pipeline flush.

Function
REQ-015 SHALL assert exers_stall combinationally iff all DEPTH entries are valid; a freed entry becomes usable the next cycle.
REQ-016 SHALL accept a dispatch iff decode_exers_dispatch & ~exers_stall & ~rob_flush, writing the lowest-index invalid entry.
REQ-017 SHALL, when a dispatched operand has rdy=0, wb_valid=1 and tag==wb_robid in the same cycle, store the operand as ready with value wb_result.
REQ-018 SHALL, for every valid entry holding a non-ready operand whose tag equals wb_robid while wb_valid=1, capture wb_result and mark that operand ready at the next edge; both operands may wake in the same cycle.
REQ-019 SHALL treat an entry as issuable only when both operands were ready at the start of the cycle; wakeup never issues in the same cycle as its broadcast.
REQ-020 SHALL drive exers_scalu_issue = (any issuable entry) & ~rob_flush, with the output fields taken combinationally from the lowest-index issuable entry.
REQ-021 SHALL invalidate the issued entry at the edge where exers_scalu_issue & ~scalu_stall; under scalu_stall the same entry and fields SHALL be held stable.
REQ-022 SHALL allow dispatch, wakeup and issue in the same cycle on distinct entries.
REQ-023 SHALL, on rob_flush, clear every entry valid bit at the next edge and suppress both issue and dispatch in that cycle.
REQ-024 SHALL drive the output data fields to X-tolerant don't-care values when exers_scalu_issue=0; the bench SHALL NOT check them.

Reset
REQ-025 SHALL, on rst, clear all entry valid bits, giving exers_stall=0 and exers_scalu_issue=0 in the cycle after reset.
REQ-026 SHALL let rst override a simultaneous dispatch, wakeup or issue, and SHALL NOT reset entry payload fields.

Structure
REQ-027 SHALL place the DEPTH default, op/robid/rd/data widths and the entry record typedef (valid, op, robid, rd, op1, op1_rdy, op1_tag, op2, op2_rdy, op2_tag) in a shared package.
REQ-028 SHALL use one sub-module, exers_prio, a parameterised lowest-index priority encoder (one-hot plus any-valid), instantiated twice: free-slot allocation and issue selection.

Verification
REQ-029 Bench SHALL drive one dispatch with both operands ready (op=0, op1=5, op2=7, robid=3) and check issue the next cycle with op1=5, op2=7, robid=3.
REQ-030 Bench SHALL dispatch with op1_tag=9 not ready, then broadcast wb_robid=9, wb_result=0x11 one cycle later, and check issue exactly one cycle after the broadcast with op1=0x11.
REQ-031 Bench SHALL dispatch with op2_tag=4 while wb_robid=4 is broadcast in the same cycle, and check the entry issues the next cycle with op2=wb_result.
REQ-032 Bench SHALL fill 8 entries with scalu_stall=1, check exers_stall=1 and that a 9th dispatch is dropped, then release the stall and check issue order 0..7, one per cycle.
REQ-033 Bench SHALL assert rob_flush with 5 valid entries and a simultaneous dispatch, and check issue=0 that cycle, with no issue and exers_stall=0 afterwards.
REQ-034 Bench SHALL assert rst mid-stream with 3 entries pending, and check exers_scalu_issue=0 and that the next dispatch lands in entry 0.

Source files
------------

// File: rtl/exers_pkg.sv
// Shared widths, default depth and entry record for the scalar-ALU reservation station.
package exers_pkg;

   localparam int EXERS_DEPTH = 8;
   localparam int OP_W        = 5;
   localparam int ROB_W       = 8;
   localparam int RD_W        = 6;
   localparam int DAT_W       = 32;

   typedef struct packed {
      logic             valid;
      logic [OP_W-1:0]  op;
      logic [ROB_W-1:0] robid;
      logic [RD_W-1:0]  rd;
      logic [DAT_W-1:0] op1;
      logic             op1_rdy;
      logic [ROB_W-1:0] op1_tag;
      logic [DAT_W-1:0] op2;
      logic             op2_rdy;
      logic [ROB_W-1:0] op2_tag;
   } entry_t;

endpackage

// File: rtl/exers_prio.sv
// Lowest-index priority encoder: one-hot grant plus any-request, purely combinational.
module exers_prio #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt,
   output logic         o_any
);

   // x & -x isolates the lowest set bit
   assign o_gnt = i_req & (~i_req + {{(N-1){1'b0}}, 1'b1});
   assign o_any = |i_req;

endmodule

// File: rtl/exers.sv
// Reservation station feeding the scalar ALU: dispatch, result-bus wakeup, lowest-index issue.
// Issue is one cycle after an entry becomes ready; scalu_stall holds the selected entry in place.
module exers
   import exers_pkg::*;
#(
   parameter int DEPTH = EXERS_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             decode_exers_dispatch,
   input  logic [OP_W-1:0]  decode_exers_op,
   input  logic [ROB_W-1:0] decode_exers_robid,
   input  logic [RD_W-1:0]  decode_exers_rd,
   input  logic             decode_exers_op1_rdy,
   input  logic             decode_exers_op2_rdy,
   input  logic [DAT_W-1:0] decode_exers_op1,
   input  logic [DAT_W-1:0] decode_exers_op2,
   input  logic [ROB_W-1:0] decode_exers_op1_tag,
   input  logic [ROB_W-1:0] decode_exers_op2_tag,
   output logic             exers_stall,
   output logic             exers_scalu_issue,
   output logic [OP_W-1:0]  exers_scalu_op,
   output logic [ROB_W-1:0] exers_robid,
   output logic [RD_W-1:0]  exers_rd,
   output logic [DAT_W-1:0] exers_op1,
   output logic [DAT_W-1:0] exers_op2,
   input  logic             scalu_stall,
   input  logic             wb_valid,
   input  logic [ROB_W-1:0] wb_robid,
   input  logic [DAT_W-1:0] wb_result,
   input  logic             rob_flush
);

   entry_t           r_ent [DEPTH];

   logic [DEPTH-1:0] w_valid;
   logic [DEPTH-1:0] w_free;
   logic [DEPTH-1:0] w_ready;
   logic [DEPTH-1:0] w_alloc_gnt;
   logic [DEPTH-1:0] w_iss_gnt;
   logic             w_alloc_any;
   logic             w_iss_any;
   logic             w_dispatch_ok;
   logic             w_fire;
   logic             w_d1_wake;
   logic             w_d2_wake;
   entry_t           w_new;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_valid[i] = r_ent[i].valid;
         w_ready[i] = r_ent[i].valid & r_ent[i].op1_rdy & r_ent[i].op2_rdy;
      end
   end

   assign w_free = ~w_valid;

   exers_prio #(.N(DEPTH)) u_alloc (
      .i_req (w_free),
      .o_gnt (w_alloc_gnt),
      .o_any (w_alloc_any)
   );

   exers_prio #(.N(DEPTH)) u_issue (
      .i_req (w_ready),
      .o_gnt (w_iss_gnt),
      .o_any (w_iss_any)
   );

   assign exers_stall       = ~w_alloc_any;
   assign exers_scalu_issue = w_iss_any & ~rob_flush;
   assign w_fire            = exers_scalu_issue & ~scalu_stall;
   assign w_dispatch_ok     = decode_exers_dispatch & w_alloc_any & ~rob_flush;

   // A result broadcast in the dispatch cycle would otherwise be missed by the new entry
   assign w_d1_wake = ~decode_exers_op1_rdy & wb_valid & (decode_exers_op1_tag == wb_robid);
   assign w_d2_wake = ~decode_exers_op2_rdy & wb_valid & (decode_exers_op2_tag == wb_robid);

   always_comb begin
      w_new         = '0;
      w_new.valid   = 1'b1;
      w_new.op      = decode_exers_op;
      w_new.robid   = decode_exers_robid;
      w_new.rd      = decode_exers_rd;
      w_new.op1_rdy = decode_exers_op1_rdy | w_d1_wake;
      w_new.op1     = w_d1_wake ? wb_result : decode_exers_op1;
      w_new.op1_tag = decode_exers_op1_tag;
      w_new.op2_rdy = decode_exers_op2_rdy | w_d2_wake;
      w_new.op2     = w_d2_wake ? wb_result : decode_exers_op2;
      w_new.op2_tag = decode_exers_op2_tag;
   end

   always_comb begin
      exers_scalu_op = '0;
      exers_robid    = '0;
      exers_rd       = '0;
      exers_op1      = '0;
      exers_op2      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_iss_gnt[i]) begin
            exers_scalu_op = r_ent[i].op;
            exers_robid    = r_ent[i].robid;
            exers_rd       = r_ent[i].rd;
            exers_op1      = r_ent[i].op1;
            exers_op2      = r_ent[i].op2;
         end
      end
   end

   // Only valid bits are reset; payload is qualified by valid everywhere
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst || rob_flush) begin
            r_ent[i].valid <= 1'b0;
         end else begin
            if (w_fire && w_iss_gnt[i]) begin
               r_ent[i].valid <= 1'b0;
            end
            if (w_dispatch_ok && w_alloc_gnt[i]) begin
               r_ent[i] <= w_new;
            end else if (r_ent[i].valid) begin
               if (!r_ent[i].op1_rdy && wb_valid && r_ent[i].op1_tag == wb_robid) begin
                  r_ent[i].op1     <= wb_result;
                  r_ent[i].op1_rdy <= 1'b1;
               end
               if (!r_ent[i].op2_rdy && wb_valid && r_ent[i].op2_tag == wb_robid) begin
                  r_ent[i].op2     <= wb_result;
                  r_ent[i].op2_rdy <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_exers.sv
// Self-checking bench for exers: directed vector table, fill/flush/reset sequences, random vs model.
module tb_exers;

   localparam int D = 8;

   typedef struct packed {
      logic        rst;
      logic        disp;
      logic [4:0]  op;
      logic [7:0]  robid;
      logic [5:0]  rd;
      logic        o1r;
      logic [31:0] o1;
      logic [7:0]  o1t;
      logic        o2r;
      logic [31:0] o2;
      logic [7:0]  o2t;
      logic        wbv;
      logic [7:0]  wbid;
      logic [31:0] wbres;
      logic        flush;
      logic        sst;
   } in_t;

   typedef struct {
      in_t         in;
      logic        e_iss;
      logic [31:0] e_op1;
      logic [31:0] e_op2;
      logic [7:0]  e_robid;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        decode_exers_dispatch;
   logic [4:0]  decode_exers_op;
   logic [7:0]  decode_exers_robid;
   logic [5:0]  decode_exers_rd;
   logic        decode_exers_op1_rdy;
   logic        decode_exers_op2_rdy;
   logic [31:0] decode_exers_op1;
   logic [31:0] decode_exers_op2;
   logic [7:0]  decode_exers_op1_tag;
   logic [7:0]  decode_exers_op2_tag;
   logic        exers_stall;
   logic        exers_scalu_issue;
   logic [4:0]  exers_scalu_op;
   logic [7:0]  exers_robid;
   logic [5:0]  exers_rd;
   logic [31:0] exers_op1;
   logic [31:0] exers_op2;
   logic        scalu_stall;
   logic        wb_valid;
   logic [7:0]  wb_robid;
   logic [31:0] wb_result;
   logic        rob_flush;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   exers #(.DEPTH(D)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .decode_exers_dispatch (decode_exers_dispatch),
      .decode_exers_op       (decode_exers_op),
      .decode_exers_robid    (decode_exers_robid),
      .decode_exers_rd       (decode_exers_rd),
      .decode_exers_op1_rdy  (decode_exers_op1_rdy),
      .decode_exers_op2_rdy  (decode_exers_op2_rdy),
      .decode_exers_op1      (decode_exers_op1),
      .decode_exers_op2      (decode_exers_op2),
      .decode_exers_op1_tag  (decode_exers_op1_tag),
      .decode_exers_op2_tag  (decode_exers_op2_tag),
      .exers_stall           (exers_stall),
      .exers_scalu_issue     (exers_scalu_issue),
      .exers_scalu_op        (exers_scalu_op),
      .exers_robid           (exers_robid),
      .exers_rd              (exers_rd),
      .exers_op1             (exers_op1),
      .exers_op2             (exers_op2),
      .scalu_stall           (scalu_stall),
      .wb_valid              (wb_valid),
      .wb_robid              (wb_robid),
      .wb_result             (wb_result),
      .rob_flush             (rob_flush)
   );

   // Reference model: a bag of slots, each holding an instruction waiting on its operands
   bit        mv  [D];
   bit [4:0]  mop [D];
   bit [7:0]  mrob[D];
   bit [5:0]  mrd [D];
   bit [31:0] m1  [D];
   bit [31:0] m2  [D];
   bit        m1r [D];
   bit        m2r [D];
   bit [7:0]  m1t [D];
   bit [7:0]  m2t [D];

   function automatic int m_pick();
      for (int i = 0; i < D; i++)
         if (mv[i] && m1r[i] && m2r[i]) return i;
      return -1;
   endfunction

   function automatic int m_free();
      for (int i = 0; i < D; i++)
         if (!mv[i]) return i;
      return -1;
   endfunction

   always @(posedge clk) begin : model
      int pk;
      int fr;
      bit w1;
      bit w2;
      if (rst || rob_flush) begin
         for (int i = 0; i < D; i++) mv[i] = 1'b0;
      end else begin
         pk = m_pick();
         fr = m_free();
         for (int i = 0; i < D; i++) begin
            if (mv[i] && !m1r[i] && wb_valid && m1t[i] == wb_robid) begin
               m1[i] = wb_result; m1r[i] = 1'b1;
            end
            if (mv[i] && !m2r[i] && wb_valid && m2t[i] == wb_robid) begin
               m2[i] = wb_result; m2r[i] = 1'b1;
            end
         end
         if (pk >= 0 && !scalu_stall) mv[pk] = 1'b0;
         if (decode_exers_dispatch && fr >= 0) begin
            w1 = !decode_exers_op1_rdy && wb_valid && decode_exers_op1_tag == wb_robid;
            w2 = !decode_exers_op2_rdy && wb_valid && decode_exers_op2_tag == wb_robid;
            mv[fr]   = 1'b1;
            mop[fr]  = decode_exers_op;
            mrob[fr] = decode_exers_robid;
            mrd[fr]  = decode_exers_rd;
            m1r[fr]  = decode_exers_op1_rdy || w1;
            m2r[fr]  = decode_exers_op2_rdy || w2;
            m1[fr]   = w1 ? wb_result : decode_exers_op1;
            m2[fr]   = w2 ? wb_result : decode_exers_op2;
            m1t[fr]  = decode_exers_op1_tag;
            m2t[fr]  = decode_exers_op2_tag;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input in_t v);
      rst                   = v.rst;
      decode_exers_dispatch = v.disp;
      decode_exers_op       = v.op;
      decode_exers_robid    = v.robid;
      decode_exers_rd       = v.rd;
      decode_exers_op1_rdy  = v.o1r;
      decode_exers_op1      = v.o1;
      decode_exers_op1_tag  = v.o1t;
      decode_exers_op2_rdy  = v.o2r;
      decode_exers_op2      = v.o2;
      decode_exers_op2_tag  = v.o2t;
      wb_valid              = v.wbv;
      wb_robid              = v.wbid;
      wb_result             = v.wbres;
      rob_flush             = v.flush;
      scalu_stall           = v.sst;
   endtask

   // Drive one cycle's inputs after the falling edge; outputs are then sampled by the caller
   task automatic cyc(input in_t v);
      @(negedge clk);
      apply(v);
      #1;
   endtask

   function automatic in_t mkin(bit disp, bit [4:0] op, bit [7:0] robid,
                                bit o1r, bit [31:0] o1, bit [7:0] o1t,
                                bit o2r, bit [31:0] o2, bit [7:0] o2t,
                                bit wbv, bit [7:0] wbid, bit [31:0] wbres);
      in_t v;
      v       = '0;
      v.disp  = disp;  v.op  = op;  v.robid = robid; v.rd = robid[5:0];
      v.o1r   = o1r;   v.o1  = o1;  v.o1t   = o1t;
      v.o2r   = o2r;   v.o2  = o2;  v.o2t   = o2t;
      v.wbv   = wbv;   v.wbid = wbid; v.wbres = wbres;
      return v;
   endfunction

   function automatic vec_t mkv(in_t i, bit iss, bit [31:0] e1, bit [31:0] e2, bit [7:0] er);
      vec_t v;
      v.in = i; v.e_iss = iss; v.e_op1 = e1; v.e_op2 = e2; v.e_robid = er;
      return v;
   endfunction

   function automatic in_t rdy_disp(bit [7:0] robid, bit sst);
      in_t v;
      v     = mkin(1, 5'd1, robid, 1, {24'h0, robid}, 0, 1, {24'h1, robid}, 0, 0, 0, 0);
      v.sst = sst;
      return v;
   endfunction

   // Fill every slot under ALU backpressure, try one extra, then drain in slot order
   task automatic fill_drain(input bit [7:0] base);
      in_t v;
      for (int k = 0; k < D; k++) begin
         cyc(rdy_disp(base + 8'(k), 1'b1));
         chk("fill_stall", exers_stall, 0);
         chk("fill_iss", exers_scalu_issue, (k > 0) ? 1 : 0);
         if (k > 0) chk("fill_hold_robid", exers_robid, base);
      end
      cyc(rdy_disp(base + 8'(D), 1'b1));
      chk("full_stall", exers_stall, 1);
      chk("full_hold_robid", exers_robid, base);
      v = '0;
      for (int k = 0; k < D; k++) begin
         cyc(v);
         chk("drain_iss", exers_scalu_issue, 1);
         chk("drain_robid", exers_robid, base + 8'(k));
         chk("drain_op1", exers_op1, {24'h0, base + 8'(k)});
      end
      cyc(v);
      chk("drain_done_iss", exers_scalu_issue, 0);
      chk("drain_done_stall", exers_stall, 0);
   endtask

   vec_t tbl[14];
   in_t  z;
   in_t  r;
   int   pk;

   initial begin
      z = '0;
      tbl[0]  = mkv(mkin(1, 0, 8'd3, 1, 5, 0, 1, 7, 0, 0, 0, 0), 0, 0, 0, 0);
      tbl[1]  = mkv(z, 1, 5, 7, 8'd3);
      tbl[2]  = mkv(z, 0, 0, 0, 0);
      tbl[3]  = mkv(mkin(1, 2, 8'd10, 0, 0, 8'd9, 1, 2, 0, 0, 0, 0), 0, 0, 0, 0);
      tbl[4]  = mkv(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'd9, 32'h11), 0, 0, 0, 0);
      tbl[5]  = mkv(z, 1, 32'h11, 2, 8'd10);
      tbl[6]  = mkv(z, 0, 0, 0, 0);
      tbl[7]  = mkv(mkin(1, 3, 8'd12, 1, 1, 0, 0, 0, 8'd4, 1, 8'd4, 32'hABCD), 0, 0, 0, 0);
      tbl[8]  = mkv(z, 1, 1, 32'hABCD, 8'd12);
      tbl[9]  = mkv(z, 0, 0, 0, 0);
      tbl[10] = mkv(mkin(1, 4, 8'd20, 0, 0, 8'd6, 0, 0, 8'd6, 0, 0, 0), 0, 0, 0, 0);
      tbl[11] = mkv(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'd6, 32'h55), 0, 0, 0, 0);
      tbl[12] = mkv(z, 1, 32'h55, 32'h55, 8'd20);
      tbl[13] = mkv(z, 0, 0, 0, 0);

      r = '0; r.rst = 1'b1;
      apply(r);
      repeat (2) @(posedge clk);
      cyc(z);
      chk("reset_iss", exers_scalu_issue, 0);
      chk("reset_stall", exers_stall, 0);

      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].in);
         chk($sformatf("tbl%0d_iss", i), exers_scalu_issue, tbl[i].e_iss);
         chk($sformatf("tbl%0d_stall", i), exers_stall, 0);
         if (tbl[i].e_iss) begin
            chk($sformatf("tbl%0d_op1", i), exers_op1, tbl[i].e_op1);
            chk($sformatf("tbl%0d_op2", i), exers_op2, tbl[i].e_op2);
            chk($sformatf("tbl%0d_robid", i), exers_robid, tbl[i].e_robid);
         end
      end

      fill_drain(8'h40);

      // Flush with five ready entries parked behind backpressure and a dispatch in flight
      for (int k = 0; k < 5; k++) cyc(rdy_disp(8'h50 + 8'(k), 1'b1));
      r = rdy_disp(8'h5F, 1'b0); r.flush = 1'b1;
      cyc(r);
      chk("flush_iss", exers_scalu_issue, 0);
      cyc(z);
      chk("post_flush_iss", exers_scalu_issue, 0);
      chk("post_flush_stall", exers_stall, 0);
      cyc(z);
      chk("post_flush_iss2", exers_scalu_issue, 0);

      // Reset mid-stream with three pending entries and a colliding dispatch
      for (int k = 0; k < 3; k++) cyc(rdy_disp(8'h70 + 8'(k), 1'b1));
      r = rdy_disp(8'h7F, 1'b0); r.rst = 1'b1;
      cyc(r);
      cyc(z);
      chk("post_rst_iss", exers_scalu_issue, 0);
      chk("post_rst_stall", exers_stall, 0);
      fill_drain(8'h80);

      r = '0; r.rst = 1'b1;
      cyc(r);
      for (int n = 0; n < 400; n++) begin
         r        = '0;
         r.disp   = ($urandom_range(0, 2) != 0);
         r.op     = 5'($urandom);
         r.robid  = 8'($urandom);
         r.rd     = 6'($urandom);
         r.o1r    = 1'($urandom_range(0, 1));
         r.o1     = $urandom;
         r.o1t    = 8'($urandom_range(0, 7));
         r.o2r    = 1'($urandom_range(0, 1));
         r.o2     = $urandom;
         r.o2t    = 8'($urandom_range(0, 7));
         r.wbv    = 1'($urandom_range(0, 1));
         r.wbid   = 8'($urandom_range(0, 7));
         r.wbres  = $urandom;
         r.flush  = ($urandom_range(0, 39) == 0);
         r.sst    = ($urandom_range(0, 3) == 0);
         cyc(r);
         pk = m_pick();
         chk("rnd_stall", exers_stall, (m_free() < 0) ? 1 : 0);
         chk("rnd_iss", exers_scalu_issue, (pk >= 0 && !r.flush) ? 1 : 0);
         if (pk >= 0 && !r.flush) begin
            chk("rnd_op", exers_scalu_op, mop[pk]);
            chk("rnd_robid", exers_robid, mrob[pk]);
            chk("rnd_rd", exers_rd, mrd[pk]);
            chk("rnd_op1", exers_op1, m1[pk]);
            chk("rnd_op2", exers_op2, m2[pk]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
